// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired two-byte-fetch control unit driving ALUSystem selects.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter bit CLEAR_RF_ON_INIT = 1'b1,
    parameter int FLAG_Z_BIT       = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_Q,
    input  logic [3:0]  ALU_Flags,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [3:0]  Flags_Q,
    output logic [2:0]  SeqState,
    output logic        Halted
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_EXEC1   = 3'd3,
        S_EXEC2   = 3'd4,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] c_OP_LDI = 4'h0;
    localparam logic [3:0] c_OP_LDM = 4'h1;
    localparam logic [3:0] c_OP_STM = 4'h2;
    localparam logic [3:0] c_OP_MOV = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_SUB = 4'h5;
    localparam logic [3:0] c_OP_AND = 4'h6;
    localparam logic [3:0] c_OP_OR  = 4'h7;
    localparam logic [3:0] c_OP_XOR = 4'h8;
    localparam logic [3:0] c_OP_INC = 4'h9;
    localparam logic [3:0] c_OP_DEC = 4'hA;
    localparam logic [3:0] c_OP_BRA = 4'hB;
    localparam logic [3:0] c_OP_BEQ = 4'hC;
    localparam logic [3:0] c_OP_BNE = 4'hD;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flags;
    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [3:0]  w_rd_wr;
    logic        w_is_alu;
    logic        w_z;
    logic        w_take;
    logic        w_unused_imm;

    assign w_op         = IR_Q[15:12];
    assign w_rd         = IR_Q[11:10];
    assign w_rs         = IR_Q[9:8];
    // Active-low write enable for Rd: R1 sits on bit 3, R4 on bit 0.
    assign w_rd_wr      = ~(4'b1000 >> w_rd);
    assign w_is_alu     = (w_op >= c_OP_ADD) && (w_op <= c_OP_XOR);
    assign w_z          = r_flags[FLAG_Z_BIT];
    assign w_take       = (w_op == c_OP_BRA) || ((w_op == c_OP_BEQ) && w_z) ||
                          ((w_op == c_OP_BNE) && !w_z);
    assign w_unused_imm = ^IR_Q[7:0];

    assign Flags_Q  = r_flags;
    assign SeqState = r_state;
    assign Halted   = (r_state == S_HALT);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Only the ALU-op execute cycle may capture flags.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_flags <= 4'b0000;
        end else if ((r_state == S_EXEC1) && w_is_alu) begin
            r_flags <= ALU_Flags;
        end
    end

    always_comb begin
        w_next      = S_INIT;
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = 2'b00;
        RF_RegSel   = 4'b1111;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b111;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b10;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;

        case (r_state)
            S_INIT: begin
                ARF_FunSel = 2'b11;
                ARF_RegSel = 3'b000;
                if (CLEAR_RF_ON_INIT) begin
                    RF_FunSel = 2'b11;
                    RF_RegSel = 4'b0000;
                end
                w_next = S_FETCH_L;
            end
            S_FETCH_L, S_FETCH_H: begin
                ARF_OutDSel = 2'b00;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (r_state == S_FETCH_H);
                ARF_FunSel  = 2'b01;
                ARF_RegSel  = 3'b011;
                w_next      = (r_state == S_FETCH_L) ? S_FETCH_H : S_EXEC1;
            end
            S_EXEC1: begin
                w_next = S_FETCH_L;
                if (w_op <= c_OP_DEC) begin
                    RF_OutASel = w_rd;
                    RF_OutBSel = w_rs;
                end
                case (w_op)
                    c_OP_LDI: begin
                        MuxASel   = 2'b00;
                        RF_FunSel = 2'b10;
                        RF_RegSel = w_rd_wr;
                    end
                    c_OP_LDM, c_OP_STM: begin
                        MuxBSel    = 2'b01;
                        ARF_FunSel = 2'b10;
                        ARF_RegSel = 3'b101;
                        w_next     = S_EXEC2;
                    end
                    c_OP_MOV: begin
                        RF_OutASel = w_rs;
                        MuxCSel    = 1'b1;
                        ALU_FunSel = 4'b0000;
                        MuxASel    = 2'b11;
                        RF_FunSel  = 2'b10;
                        RF_RegSel  = w_rd_wr;
                    end
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
                        MuxCSel   = 1'b1;
                        MuxASel   = 2'b11;
                        RF_FunSel = 2'b10;
                        RF_RegSel = w_rd_wr;
                        case (w_op)
                            c_OP_ADD: ALU_FunSel = 4'b0100;
                            c_OP_SUB: ALU_FunSel = 4'b0110;
                            c_OP_AND: ALU_FunSel = 4'b0111;
                            c_OP_OR:  ALU_FunSel = 4'b1000;
                            default:  ALU_FunSel = 4'b1001;
                        endcase
                    end
                    c_OP_INC, c_OP_DEC: begin
                        RF_FunSel = (w_op == c_OP_INC) ? 2'b01 : 2'b00;
                        RF_RegSel = w_rd_wr;
                    end
                    c_OP_BRA, c_OP_BEQ, c_OP_BNE: begin
                        if (w_take) begin
                            MuxBSel    = 2'b01;
                            ARF_FunSel = 2'b10;
                            ARF_RegSel = 3'b011;
                        end
                    end
                    c_OP_HLT: w_next = S_HALT;
                    default: ;
                endcase
            end
            S_EXEC2: begin
                w_next = S_FETCH_L;
                if (w_op == c_OP_LDM) begin
                    ARF_OutDSel = 2'b10;
                    Mem_CS      = 1'b0;
                    MuxASel     = 2'b01;
                    RF_FunSel   = 2'b10;
                    RF_RegSel   = w_rd_wr;
                end else if (w_op == c_OP_STM) begin
                    ARF_OutDSel = 2'b10;
                    RF_OutASel  = w_rd;
                    MuxCSel     = 1'b1;
                    ALU_FunSel  = 4'b0000;
                    Mem_CS      = 1'b0;
                    Mem_WR      = 1'b1;
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_INIT;
        endcase
    end

endmodule
`default_nettype wire
